// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: rebuilds 640x480@60 position counters from an incoming
// hsync/vsync pair, measures line/frame/sync timing and reports lock + errors.
// Latency: h_pos/v_pos lag the source counters by 1 clk; active/px_x/px_y are
// combinational from the registered counters.
// Backpressure: none; the monitor observes every cycle and cannot stall the source.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   hsync_in          active-low horizontal sync
//   vsync_in          active-low vertical sync (changes only on hsync falling-edge cycles)
//   h_pos, v_pos      recovered horizontal/vertical counts, saturating at 1023
//   px_x, px_y        coordinates inside the visible window, 0 outside it
//   active            visible window and locked
//   line_len          clocks in the last complete line
//   frame_lines       lines in the last complete frame
//   locked            timing verified over LOCK_FRAMES consecutive frames
//   err               one-cycle pulse per cycle in which any timing check fails
module vga_timing_monitor #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        active,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        err
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE - 1;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE - 1;

  typedef enum logic [1:0] {UNLOCKED, COUNTING, LOCKED} state_t;

  state_t      state, state_n;
  logic [7:0]  good_cnt, good_n;
  logic        frame_err, frame_err_n;
  logic        hs_d, vs_d;
  logic        h_seen, v_seen;
  logic [10:0] hlow, vlow;

  logic        hs_fe, hs_re, vs_fe, vs_re;
  logic [10:0] h_inc, v_inc;
  logic        chk_hlen, chk_hsw, chk_vlen, chk_vsw, any_chk;

  // Edge detection. Vertical edges are only honoured on hsync falling-edge
  // cycles, which is the only place a well-formed source moves vsync.
  assign hs_fe = ~hsync_in & hs_d;
  assign hs_re = hsync_in & ~hs_d;
  assign vs_fe = hs_fe & ~vsync_in & vs_d;
  assign vs_re = hs_fe & vsync_in & ~vs_d;

  // 11-bit so a saturated counter (1023) reports a length of 1024.
  assign h_inc = {1'b0, h_pos} + 11'd1;
  assign v_inc = {1'b0, v_pos} + 11'd1;

  // Checks are only meaningful once a full line/frame has been framed by an
  // edge seen since reset, so partial intervals after reset never flag.
  assign chk_hlen = hs_fe & h_seen & (h_inc != 11'(H_TOTAL));
  assign chk_hsw  = hs_re & h_seen & (hlow  != 11'(H_SYNC));
  assign chk_vlen = vs_fe & v_seen & (v_inc != 11'(V_TOTAL));
  assign chk_vsw  = vs_re & v_seen & (vlow  != 11'(V_SYNC));
  assign any_chk  = chk_hlen | chk_hsw | chk_vlen | chk_vsw;

  // Lock FSM next state. A failing check drops lock immediately; the frame
  // boundary decides whether the just-finished frame counts as good.
  always_comb begin
    state_n     = state;
    good_n      = good_cnt;
    frame_err_n = frame_err;
    if (any_chk) begin
      state_n     = UNLOCKED;
      frame_err_n = 1'b1;
    end
    if (vs_fe) begin
      frame_err_n = 1'b0;
      if (v_seen) begin
        if (frame_err || any_chk) begin
          good_n  = 8'd0;
          state_n = UNLOCKED;
        end else begin
          if (good_cnt < 8'(LOCK_FRAMES)) begin
            good_n = good_cnt + 8'd1;
          end
          state_n = (good_n == 8'(LOCK_FRAMES)) ? LOCKED : COUNTING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      good_cnt    <= 8'd0;
      frame_err   <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      hlow        <= 11'd0;
      vlow        <= 11'd0;
      h_pos       <= 10'd0;
      v_pos       <= 10'd0;
      line_len    <= 11'd0;
      frame_lines <= 11'd0;
      err         <= 1'b0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_n;
      frame_err <= frame_err_n;
      hs_d      <= hsync_in;
      vs_d      <= vsync_in;
      err       <= any_chk;

      // Horizontal position and sync-low width.
      if (hs_fe) begin
        h_pos  <= 10'd0;
        h_seen <= 1'b1;
        if (h_seen) line_len <= h_inc;
      end else if (h_pos != 10'd1023) begin
        h_pos <= h_pos + 10'd1;
      end

      if (hs_fe) begin
        hlow <= 11'd1;
      end else if (!hsync_in && hlow != 11'd2047) begin
        hlow <= hlow + 11'd1;
      end

      // Vertical position and sync-low width, both in lines.
      if (hs_fe) begin
        if (vs_fe) begin
          v_pos  <= 10'd0;
          v_seen <= 1'b1;
          if (v_seen) frame_lines <= v_inc;
        end else if (v_pos != 10'd1023) begin
          v_pos <= v_pos + 10'd1;
        end
      end

      if (vs_fe) begin
        vlow <= 11'd1;
      end else if (hs_fe && !vsync_in && vlow != 11'd2047) begin
        vlow <= vlow + 11'd1;
      end
    end
  end

  assign locked = (state == LOCKED);

  assign active = locked
                  && (h_pos >= 10'(H_START)) && (h_pos <= 10'(H_END))
                  && (v_pos >= 10'(V_START)) && (v_pos <= 10'(V_END));

  assign px_x = active ? (h_pos - 10'(H_START)) : 10'd0;
  assign px_y = active ? (v_pos - 10'(V_START)) : 10'd0;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down raster
// (32 clocks x 13 lines) so several frames fit in a short run.
module tb_vga_timing_monitor;

  localparam int HS = 8, HB = 4, HA = 16, HF = 4;
  localparam int VS = 2, VB = 3, VA = 6, VF = 2;
  localparam int HT = HS + HB + HA + HF;   // 32
  localparam int VT = VS + VB + VA + VF;   // 13

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  h_pos, v_pos, px_x, px_y;
  logic        active, locked, err;
  logic [10:0] line_len, frame_lines;

  vga_timing_monitor #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_pos(h_pos), .v_pos(v_pos), .px_x(px_x), .px_y(px_y),
    .active(active), .line_len(line_len), .frame_lines(frame_lines),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_cnt = 0;

  // Source generator state: position of the next cycle to drive, plus
  // one-shot overrides for the current line length and hsync width.
  int gh = 5, gv = 7;
  int llen = HT, hsw = HS;
  int ah = 0, av = 0;

  typedef struct {
    int gh; int gv; int act; int x; int y;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one source cycle, let the DUT clock it, sample 1ns later.
  task automatic cyc();
    hsync_in = (gh < hsw) ? 1'b0 : 1'b1;
    vsync_in = (gv < VS) ? 1'b0 : 1'b1;
    ah = gh;
    av = gv;
    @(posedge clk);
    #1;
    if (err) err_cnt++;
    gh++;
    if (gh >= llen) begin
      gh   = 0;
      gv   = (gv + 1) % VT;
      llen = HT;
      hsw  = HS;
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (ah == h && av == v) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout waiting for h=%0d v=%0d", tag, h, v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " h_pos"}, int'(h_pos), 0);
    chk({tag, " v_pos"}, int'(v_pos), 0);
    chk({tag, " px_x"}, int'(px_x), 0);
    chk({tag, " px_y"}, int'(px_y), 0);
    chk({tag, " active"}, int'(active), 0);
    chk({tag, " line_len"}, int'(line_len), 0);
    chk({tag, " frame_lines"}, int'(frame_lines), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  initial begin
    int base;

    // Visible window is h 12..27, v 5..10.
    tbl[0] = '{gh: 12, gv: 5,  act: 1, x: 0,  y: 0};
    tbl[1] = '{gh: 27, gv: 10, act: 1, x: 15, y: 5};
    tbl[2] = '{gh: 28, gv: 10, act: 0, x: 0,  y: 0};
    tbl[3] = '{gh: 11, gv: 5,  act: 0, x: 0,  y: 0};
    tbl[4] = '{gh: 12, gv: 4,  act: 0, x: 0,  y: 0};
    tbl[5] = '{gh: 20, gv: 7,  act: 1, x: 8,  y: 2};
    tbl[6] = '{gh: 27, gv: 11, act: 0, x: 0,  y: 0};

    // Reset with the source running mid-frame.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Clean lock: first frame start only arms, two good frames then lock.
    run_to(0, 0, "lock fe1");
    chk("lock fe1 locked", int'(locked), 0);
    chk("lock fe1 frame_lines", int'(frame_lines), 0);
    chk("lock fe1 line_len", int'(line_len), HT);
    chk("latency h_pos", int'(h_pos), 0);
    run_to(0, 0, "lock fe2");
    chk("lock fe2 frame_lines", int'(frame_lines), VT);
    chk("lock fe2 locked", int'(locked), 0);
    run_to(0, 0, "lock fe3");
    chk("lock fe3 locked", int'(locked), 1);
    chk("lock err count", err_cnt, 0);

    // Visible window alignment.
    foreach (tbl[k]) begin
      run_to(tbl[k].gh, tbl[k].gv, "align");
      chk($sformatf("align%0d h_pos", k), int'(h_pos), tbl[k].gh);
      chk($sformatf("align%0d v_pos", k), int'(v_pos), tbl[k].gv);
      chk($sformatf("align%0d active", k), int'(active), tbl[k].act);
      chk($sformatf("align%0d px_x", k), int'(px_x), tbl[k].x);
      chk($sformatf("align%0d px_y", k), int'(px_y), tbl[k].y);
    end
    chk("align err count", err_cnt, 0);

    // Short line (31 clocks) on line 6.
    base = err_cnt;
    run_to(HT - 1, 5, "short pre");
    llen = HT - 1;
    run_to(0, 7, "short fe");
    chk("short err", int'(err), 1);
    chk("short line_len", int'(line_len), HT - 1);
    cyc();
    chk("short err width", int'(err), 0);
    chk("short locked", int'(locked), 0);
    run_to(0, 0, "short relock1");
    run_to(0, 0, "short relock2");
    chk("short relock2 locked", int'(locked), 0);
    run_to(0, 0, "short relock3");
    chk("short relock3 locked", int'(locked), 1);
    chk("short err count", err_cnt - base, 1);

    // Narrow hsync (7 clocks) on line 3.
    base = err_cnt;
    run_to(HT - 1, 2, "narrow pre");
    hsw = HS - 1;
    run_to(HS - 1, 3, "narrow re");
    chk("narrow err", int'(err), 1);
    cyc();
    chk("narrow err width", int'(err), 0);
    chk("narrow locked", int'(locked), 0);
    run_to(0, 4, "narrow next line");
    chk("narrow line_len", int'(line_len), HT);
    run_to(0, 0, "narrow relock1");
    run_to(0, 0, "narrow relock2");
    run_to(0, 0, "narrow relock3");
    chk("narrow relock locked", int'(locked), 1);
    chk("narrow err count", err_cnt - base, 1);

    // Reset in the middle of a frame.
    run_to(20, 8, "midrst pre");
    rst = 1'b1;
    cyc();
    chk_reset_vals("midrst");
    rst = 1'b0;
    base = err_cnt;
    run_to(0, 0, "midrst fe1");
    run_to(0, 0, "midrst fe2");
    chk("midrst fe2 locked", int'(locked), 0);
    run_to(0, 0, "midrst fe3");
    chk("midrst fe3 locked", int'(locked), 1);
    chk("midrst err count", err_cnt - base, 0);

    // Stuck hsync: high for 1500 clocks after an 8-clock pulse on line 3.
    base = err_cnt;
    run_to(HT - 1, 2, "stuck pre");
    llen = HS + 1500;
    run_to(1030, 3, "stuck sat");
    chk("stuck h_pos sat", int'(h_pos), 1023);
    chk("stuck locked held", int'(locked), 1);
    chk("stuck no early err", err_cnt - base, 0);
    run_to(0, 4, "stuck fe");
    chk("stuck line_len", int'(line_len), 1024);
    chk("stuck err", int'(err), 1);
    chk("stuck h_pos clear", int'(h_pos), 0);
    cyc();
    chk("stuck locked", int'(locked), 0);
    chk("stuck err width", int'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

- Sink-side counterpart to the 640x480@60 Hz sync generator.
- Samples an incoming hsync/vsync pair in the same clock domain and rebuilds the horizontal and vertical position counters from the sync edges.
- Measures line length, frame height and sync pulse widths, checks them against the nominal timing, and reports lock and error status.
- Drives pixel coordinates and an active-video flag to downstream capture and overlay logic.

## Interface

Parameters:
- H_SYNC, 96, hsync low width in clocks
- H_BP, 48, horizontal back porch in clocks
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- V_SYNC, 2, vsync low width in lines
- V_BP, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- LOCK_FRAMES, 2, consecutive good frames required to assert lock

Derived: H_TOTAL = 800, V_TOTAL = 525.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hsync_in  in  1  active-low horizontal sync, same clock domain
- vsync_in  in  1  active-low vertical sync, changes only on hsync falling-edge cycles
- h_pos  out  10  recovered horizontal count, saturates at 1023
- v_pos  out  10  recovered line count, saturates at 1023
- px_x  out  10  h_pos − (H_SYNC+H_BP) when active, else 0
- px_y  out  10  v_pos − (V_SYNC+V_BP) when active, else 0
- active  out  1  inside visible window and locked
- line_len  out  11  length in clocks of the last complete line
- frame_lines  out  11  line count of the last complete frame
- locked  out  1  timing verified
- err  out  1  one-cycle pulse per detected mismatch

## Operation

**Input sampling**
- hs_d and vs_d are one-cycle delayed copies of the inputs; both reset to 1.
- Falling edge (FE): input = 0 and delayed copy = 1. Rising edge (RE): input = 1 and delayed copy = 0.

**Horizontal counter**
- On hsync FE: h_pos <= 0.
- On hsync FE with h_seen set: line_len <= h_pos+1. This is 11-bit arithmetic, so 1023+1 = 1024. Then set h_seen.
- Otherwise h_pos increments, holding at 1023.
- hlow counts clocks with hsync_in low.

**Vertical counter**
- Updates only on hsync FE cycles.
- If vsync FE is in the same cycle: v_pos <= 0, and if v_seen is set, frame_lines <= v_pos+1. Then set v_seen.
- Otherwise v_pos increments, holding at 1023.
- vlow counts hsync FEs seen while vsync_in is low.

**Checks** (err pulses for one cycle if any fire):
- hsync FE with h_seen: h_pos+1 ≠ H_TOTAL.
- hsync RE with h_seen: hlow ≠ H_SYNC.
- vsync FE with v_seen: v_pos+1 ≠ V_TOTAL.
- vsync RE with v_seen: vlow ≠ V_SYNC.

**Lock state machine**
- States: UNLOCKED, COUNTING, LOCKED.
- frame_err is a sticky flag. It is set by any check, and cleared on each vsync FE after that edge has been evaluated.
- On vsync FE with v_seen:
  - If frame_err (including a check firing that same cycle): good_cnt <= 0, go to UNLOCKED.
  - Else good_cnt increments, saturating at LOCK_FRAMES.
  - Reaching LOCK_FRAMES moves to LOCKED.
  - The first vsync FE after reset only sets v_seen and clears frame_err; it is never counted.
- Any err in LOCKED drops locked on the next cycle. No wait for frame end.

**Active window**
- active = locked AND 144 ≤ h_pos ≤ 783 AND 35 ≤ v_pos ≤ 514.

## Timing

- **Latency:** h_pos/v_pos at cycle t+1 equal the generator's h_count/v_count at cycle t.
- **Output update:** active, px_x, px_y are combinational from the registered counters and locked. All other outputs are registered.
- **err:** asserted the cycle after the offending edge is sampled, for exactly 1 cycle.
- **locked:** rises the cycle after the qualifying vsync FE.
- **Reset values:** h_pos = 0, v_pos = 0, px_x = 0, px_y = 0, active = 0, line_len = 0, frame_lines = 0, locked = 0, err = 0. Also good_cnt = 0, h_seen = 0, v_seen = 0, frame_err = 0, hlow = 0, vlow = 0.
- **Reset mid-frame:** everything returns to the reset values next cycle. No err is issued for the partial line or frame that follows.
- **Simultaneous events:**
  - hsync FE and vsync FE in the same cycle are the normal frame start; both counters clear in that cycle.
  - Several checks firing in one cycle produce a single err pulse.
- **Stuck sync:**
  - Counters saturate at 1023 and never wrap.
  - locked drops only when the late edge finally arrives and is checked.

## Test plan

- **Clean lock:** reset, then clean 800x525 stream.
  - line_len = 800 from the second line; frame_lines = 525 from the second vsync FE.
  - locked = 1 one cycle after the third vsync FE (two counted good frames).
  - err never asserts.
- **Alignment:** locked stream with generator at h = 144, v = 35.
  - One cycle later: active = 1, px_x = 0, px_y = 0.
  - Generator at h = 783, v = 514 gives px_x = 639, px_y = 479.
  - Generator at h = 784 gives active = 0.
- **Short line:** one line shortened to 799 while locked.
  - err pulse of 1 cycle; line_len = 799; locked = 0 the next cycle.
  - Relock after two further clean frames.
- **Narrow hsync:** hsync low for 95 clocks on one line.
  - err at that hsync RE; locked drops; line_len stays 800.
- **Reset mid-frame:** rst asserted at v = 200.
  - All outputs take their reset values.
  - No err before the second hsync FE.
  - locked returns after the normal lock sequence.
- **Stuck hsync:** hsync held high for 1500 clocks.
  - h_pos saturates at 1023.
  - At the next FE: line_len = 1024, err = 1, locked = 0.
